field_narrow: RTL and testbench
===============================

# field_narrow

Pipelined narrowing unit: the inverse of the operand-extension path. It accepts wide values (default 5-bit) over a valid/ready handshake and produces narrow fields (default 3-bit) for immediate and register-field encoding in the 8-bit MIPS datapath. It flags every value that does not survive zero-extension round-trip and keeps a saturating overflow count. A 2-entry output buffer decouples producer and consumer without a combinational ready path.

## Interface
- IN_W, 5, input value width (> OUT_W)
- OUT_W, 3, output field width
- CNT_W, 8, overflow counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer has data
- in_ready  out  1  unit can accept
- in_data  in  IN_W  wide value
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_data  out  OUT_W  narrowed field of head
- out_ovf  out  1  head value had nonzero bits above OUT_W
- ovf_clr  in  1  synchronous clear of ovf_count
- ovf_count  out  CNT_W  saturating count of accepted overflowing values

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- On push, ovf = |in_data[IN_W-1:OUT_W]. Stored data = narrowed value (see Configuration). {ovf, data} is written to the buffer tail.
- Buffer occupancy FSM:
  - EMPTY: push → ONE.
  - ONE: push&!pop → TWO; pop&!push → EMPTY; push&pop → ONE, new entry becomes head next cycle.
  - TWO: pop → ONE; push is impossible.
- in_ready = (occupancy != TWO), decoded from registered state only; no path from out_ready.
- out_valid = (occupancy != EMPTY). out_data and out_ovf show the head entry and hold stable while out_valid & !out_ready.
- ovf_count: +1 on push with ovf=1, saturates at 2^CNT_W-1. ovf_clr with no overflowing push → 0. ovf_clr together with an overflowing push → 1. The increment is never lost.
- Reset (any time, including mid-transfer): occupancy EMPTY, out_valid 0, out_data 0, out_ovf 0, ovf_count 0. in_ready is 1 during and after reset. Buffered entries are discarded.

## Timing
- Latency: data pushed in cycle N appears on out_* with out_valid=1 in cycle N+1.
- Throughput: 1 item/cycle sustained while out_ready=1.
- With out_ready=0 from EMPTY: two pushes are accepted, then in_ready drops in the cycle after the second push.
- After a pop from TWO, in_ready rises in the next cycle.
- ovf_count reflects a push in the cycle after the push edge.
- All outputs are registered or decoded from registers.

## Configuration
- FIELD_NARROW_SAT_EN defined: overflowing values clamp to 2^OUT_W-1 (all ones).
- FIELD_NARROW_SAT_EN undefined: out_data = in_data[OUT_W-1:0] (plain truncation).
- out_ovf and ovf_count behave identically in both builds.

## Test plan
- Basic push, out_ready=1: in_data=5'b00101 → next cycle out_data=3'b101, out_ovf=0, ovf_count=0.
- Overflow: in_data=5'b01010 → out_ovf=1, ovf_count=1. out_data=3'b010 without the macro, 3'b111 with it.
- Backpressure: out_ready=0, push 5'd1, 5'd2, 5'd3 on consecutive cycles. After two accepts in_ready=0 and 5'd3 is held. Raise out_ready → outputs 1, 2, 3 in order, no loss, no duplication.
- Counter saturation and clear:
  - 256 overflowing pushes → ovf_count=255.
  - ovf_clr together with an overflowing push → 1.
  - ovf_clr alone → 0.
- Reset mid-operation: occupancy TWO, assert rst_n=0 asynchronously. out_valid goes 0 immediately and ovf_count=0. After release in_ready=1 and the next push emerges after 1 cycle.
- Streaming: 100 random values with random out_ready. Output sequence must match the reference narrowing of the input sequence, with in_ready never high in state TWO.

Source files
------------

// File: rtl/field_narrow.sv
// field_narrow: pipelined narrowing unit for the 8-bit MIPS datapath.
// Accepts IN_W-bit values over valid/ready, emits OUT_W-bit fields through a
// 2-entry output buffer, flags values that lose bits when narrowed and keeps
// a saturating count of such values.
// Build option: define FIELD_NARROW_SAT_EN to clamp overflowing values to all
// ones instead of truncating them.
module field_narrow #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  occ_e             state_q;
  logic [OUT_W-1:0] head_data_q;
  logic             head_ovf_q;
  logic [OUT_W-1:0] tail_data_q;
  logic             tail_ovf_q;
  logic [CNT_W-1:0] ovf_count_q;
  logic [CNT_W-1:0] ovf_count_d;

  logic             push;
  logic             pop;
  logic             new_ovf;
  logic [OUT_W-1:0] new_data;

  // Handshake decode; ready/valid depend only on registered occupancy.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = head_data_q;
  assign out_ovf   = head_ovf_q;
  assign ovf_count = ovf_count_q;

  // Narrow the incoming value and detect bits lost above the field.
  always_comb begin
    new_ovf  = |in_data[IN_W-1:OUT_W];
    new_data = in_data[OUT_W-1:0];
`ifdef FIELD_NARROW_SAT_EN
    if (new_ovf) begin
      new_data = {OUT_W{1'b1}};
    end else begin
      new_data = in_data[OUT_W-1:0];
    end
`endif
  end

  // Occupancy FSM with head/tail entry storage; the head drives the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      head_data_q <= {OUT_W{1'b0}};
      head_ovf_q  <= 1'b0;
      tail_data_q <= {OUT_W{1'b0}};
      tail_ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            head_data_q <= new_data;
            head_ovf_q  <= new_ovf;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && !pop) begin
            tail_data_q <= new_data;
            tail_ovf_q  <= new_ovf;
            state_q     <= ST_TWO;
          end else if (push && pop) begin
            // Head consumed this cycle; the new entry replaces it directly.
            head_data_q <= new_data;
            head_ovf_q  <= new_ovf;
          end else if (pop) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // No push can occur here because in_ready is low.
          if (pop) begin
            head_data_q <= tail_data_q;
            head_ovf_q  <= tail_ovf_q;
            state_q     <= ST_ONE;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

  // Next overflow count: clear wins over hold, but an overflowing push is kept.
  always_comb begin
    ovf_count_d = ovf_count_q;
    if (ovf_clr) begin
      if (push && new_ovf) begin
        ovf_count_d = {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        ovf_count_d = {CNT_W{1'b0}};
      end
    end else if (push && new_ovf && (ovf_count_q != CNT_MAX)) begin
      ovf_count_d = ovf_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ovf_count_d = ovf_count_q;
    end
  end

  // Overflow counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count_q <= {CNT_W{1'b0}};
    end else begin
      ovf_count_q <= ovf_count_d;
    end
  end

endmodule

// File: tb/tb_field_narrow.sv
// Self-checking bench for field_narrow: directed scenarios plus a randomized
// stream, compared against a queue-based reference model.
module tb_field_narrow;
  localparam int IN_W    = 5;
  localparam int OUT_W   = 3;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int FIELD   = (1 << OUT_W);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;
  logic             ovf_clr;
  logic [CNT_W-1:0] ovf_count;

  int n_checks = 0;
  int n_pass   = 0;
  int mdl_q[$];
  int mdl_cnt  = 0;

  field_narrow #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  function automatic int ref_ovf(input int v);
    return (v >= FIELD) ? 1 : 0;
  endfunction

  function automatic int ref_narrow(input int v);
`ifdef FIELD_NARROW_SAT_EN
    if (v >= FIELD) return FIELD - 1;
`endif
    return v % FIELD;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_outputs();
    check_eq("out_valid", 64'(out_valid), 64'(mdl_q.size() != 0));
    check_eq("in_ready",  64'(in_ready),  64'(mdl_q.size() < 2));
    check_eq("ovf_count", 64'(ovf_count), 64'(mdl_cnt));
    if (mdl_q.size() != 0) begin
      check_eq("out_data", 64'(out_data), 64'(ref_narrow(mdl_q[0])));
      check_eq("out_ovf",  64'(out_ovf),  64'(ref_ovf(mdl_q[0])));
    end
  endtask

  // One clock: check current outputs, drive inputs, advance model, step clock.
  task automatic cycle(input bit v, input int d, input bit ordy, input bit clr);
    bit push;
    bit pop;
    bit pov;
    check_outputs();
    in_valid  = v;
    in_data   = d[IN_W-1:0];
    out_ready = ordy;
    ovf_clr   = clr;
    push = v && (mdl_q.size() < 2);
    pop  = (mdl_q.size() > 0) && ordy;
    pov  = push && (ref_ovf(d) != 0);
    if (pop) void'(mdl_q.pop_front());
    if (push) mdl_q.push_back(d);
    if (clr) mdl_cnt = pov ? 1 : 0;
    else if (pov && mdl_cnt < CNT_MAX) mdl_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int pushed;
    int iters;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    #2;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready",  64'(in_ready),  64'd1);
    check_eq("rst_out_data",  64'(out_data),  64'd0);
    check_eq("rst_out_ovf",   64'(out_ovf),   64'd0);
    check_eq("rst_ovf_count", 64'(ovf_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic push and overflow with consumer always ready.
    cycle(1'b1, 5, 1'b1, 1'b0);
    check_eq("basic_data", 64'(out_data), 64'd5);
    check_eq("basic_ovf",  64'(out_ovf),  64'd0);
    cycle(1'b1, 10, 1'b1, 1'b0);
`ifdef FIELD_NARROW_SAT_EN
    check_eq("ovf_data", 64'(out_data), 64'd7);
`else
    check_eq("ovf_data", 64'(out_data), 64'd2);
`endif
    check_eq("ovf_flag",  64'(out_ovf),   64'd1);
    check_eq("ovf_cnt1",  64'(ovf_count), 64'd1);
    cycle(1'b0, 0, 1'b1, 1'b0);

    // Backpressure: two accepts, third held until the consumer drains.
    cycle(1'b1, 1, 1'b0, 1'b0);
    cycle(1'b1, 2, 1'b0, 1'b0);
    check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    cycle(1'b1, 3, 1'b0, 1'b0);
    cycle(1'b1, 3, 1'b0, 1'b0);
    check_eq("bp_head", 64'(out_data), 64'd1);
    cycle(1'b1, 3, 1'b1, 1'b0);
    check_eq("bp_second", 64'(out_data), 64'd2);
    check_eq("bp_ready_back", 64'(in_ready), 64'd1);
    cycle(1'b1, 3, 1'b1, 1'b0);
    check_eq("bp_third", 64'(out_data), 64'd3);
    cycle(1'b0, 0, 1'b1, 1'b0);
    check_eq("bp_drained", 64'(out_valid), 64'd0);

    // Counter saturation, clear with overflowing push, plain clear.
    cycle(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 256; i++) cycle(1'b1, int'($urandom_range(8, 31)), 1'b1, 1'b0);
    check_eq("sat_255", 64'(ovf_count), 64'd255);
    cycle(1'b1, 16, 1'b1, 1'b1);
    check_eq("clr_push_1", 64'(ovf_count), 64'd1);
    cycle(1'b0, 0, 1'b1, 1'b1);
    check_eq("clr_only_0", 64'(ovf_count), 64'd0);
    cycle(1'b0, 0, 1'b1, 1'b0);

    // Asynchronous reset while the buffer is full.
    cycle(1'b1, 9, 1'b0, 1'b0);
    cycle(1'b1, 12, 1'b0, 1'b0);
    check_outputs();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_cnt",   64'(ovf_count), 64'd0);
    check_eq("mid_rst_ready", 64'(in_ready),  64'd1);
    mdl_q.delete();
    mdl_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 6, 1'b1, 1'b0);
    check_eq("post_rst_valid", 64'(out_valid), 64'd1);
    check_eq("post_rst_data",  64'(out_data),  64'd6);

    // Random stream with random backpressure.
    pushed = 0;
    iters  = 0;
    while (pushed < 100 && iters < 2000) begin
      bit v;
      int d;
      v = ($urandom_range(0, 3) != 0);
      d = int'($urandom_range(0, 31));
      if (v && mdl_q.size() < 2) pushed++;
      cycle(v, d, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 15) == 0));
      iters++;
    end
    check_eq("stream_done", 64'(pushed), 64'd100);
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1, 1'b0);
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
